mochila_obi_cut: RTL and testbench

Registered OBI cut between the external-subsystem master port of the `mochila_top` cluster and the `x_heep_system` external crossbar master input (`ext_xbar_master_req_i` / `ext_xbar_master_resp_o`). It breaks all combinational paths from the cluster into the host crossbar:

- Requests pass through a small FIFO.
- Responses pass through a single register stage.
- Accepted-but-unanswered transactions are bounded by a counter, so the cluster cannot flood the crossbar.

---
 rtl/mochila_obi_cut.sv | 119 +++++++++++
 tb/tb_mochila_obi_cut.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mochila_obi_cut.sv
// Registered OBI cut between the mochila_top external master port and the
// x_heep_system external crossbar: request FIFO, response register, pending limit.
module mochila_obi_cut #(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             slv_req_i_req,
  input  logic             slv_req_i_we,
  input  logic [3:0]       slv_req_i_be,
  input  logic [31:0]      slv_req_i_addr,
  input  logic [31:0]      slv_req_i_wdata,
  output logic             slv_resp_o_gnt,
  output logic             slv_resp_o_rvalid,
  output logic [31:0]      slv_resp_o_rdata,
  output logic             mst_req_o_req,
  output logic             mst_req_o_we,
  output logic [3:0]       mst_req_o_be,
  output logic [31:0]      mst_req_o_addr,
  output logic [31:0]      mst_req_o_wdata,
  input  logic             mst_resp_i_gnt,
  input  logic             mst_resp_i_rvalid,
  input  logic [31:0]      mst_resp_i_rdata,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;
  logic [CNT_W-1:0]  pending_q;
  logic              err_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;

  logic              mem_we    [DEPTH];
  logic [3:0]        mem_be    [DEPTH];
  logic [31:0]       mem_addr  [DEPTH];
  logic [31:0]       mem_wdata [DEPTH];

  logic fifo_empty, push, pop, dec, spurious;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (fifo_cnt_q == '0);

  // Grant uses only req and registered state; a full FIFO refuses even if it pops now.
  assign slv_resp_o_gnt = slv_req_i_req && (fifo_cnt_q < FCNT_W'(DEPTH))
                          && (pending_q < CNT_W'(MAX_OUT));

  assign push     = slv_req_i_req && slv_resp_o_gnt;
  assign pop      = !fifo_empty && mst_resp_i_gnt;
  assign dec      = mst_resp_i_rvalid && (pending_q != '0);
  assign spurious = mst_resp_i_rvalid && (pending_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_we[wr_ptr_q]    <= slv_req_i_we;
      mem_be[wr_ptr_q]    <= slv_req_i_be;
      mem_addr[wr_ptr_q]  <= slv_req_i_addr;
      mem_wdata[wr_ptr_q] <= slv_req_i_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case ({push, dec})
        2'b10:   pending_q <= pending_q + CNT_W'(1);
        2'b01:   pending_q <= pending_q - CNT_W'(1);
        default: pending_q <= pending_q;
      endcase
      if (spurious) err_q <= 1'b1;
      rvalid_q <= mst_resp_i_rvalid;
      rdata_q  <= mst_resp_i_rdata;
    end
  end

  // Payload is forced to zero while empty so the port reads all-zero out of reset.
  assign mst_req_o_req   = !fifo_empty;
  assign mst_req_o_we    = fifo_empty ? 1'b0  : mem_we[rd_ptr_q];
  assign mst_req_o_be    = fifo_empty ? 4'h0  : mem_be[rd_ptr_q];
  assign mst_req_o_addr  = fifo_empty ? 32'h0 : mem_addr[rd_ptr_q];
  assign mst_req_o_wdata = fifo_empty ? 32'h0 : mem_wdata[rd_ptr_q];

  assign slv_resp_o_rvalid = rvalid_q;
  assign slv_resp_o_rdata  = rdata_q;
  assign pending_o         = pending_q;
  assign busy_o            = (pending_q != '0);
  assign err_o             = err_q;

endmodule

// File: tb/tb_mochila_obi_cut.sv
// Scoreboard bench for mochila_obi_cut: directed stimulus pushes expected
// downstream requests and upstream responses; negedge monitors pop and compare.
module tb_mochila_obi_cut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slv_req, slv_we;
  logic [3:0]  slv_be;
  logic [31:0] slv_addr, slv_wdata;
  logic        slv_gnt, slv_rvalid;
  logic [31:0] slv_rdata;
  logic        mst_req, mst_we;
  logic [3:0]  mst_be;
  logic [31:0] mst_addr, mst_wdata;
  logic        mst_gnt, mst_rvalid;
  logic [31:0] mst_rdata;
  logic [2:0]  pending;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [31:0] rdata;
    int          at;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  logic [31:0] wa[4];
  logic [31:0] wd[4];
  logic [3:0]  wb[4];

  mochila_obi_cut dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .slv_req_i_req     (slv_req),
    .slv_req_i_we      (slv_we),
    .slv_req_i_be      (slv_be),
    .slv_req_i_addr    (slv_addr),
    .slv_req_i_wdata   (slv_wdata),
    .slv_resp_o_gnt    (slv_gnt),
    .slv_resp_o_rvalid (slv_rvalid),
    .slv_resp_o_rdata  (slv_rdata),
    .mst_req_o_req     (mst_req),
    .mst_req_o_we      (mst_we),
    .mst_req_o_be      (mst_be),
    .mst_req_o_addr    (mst_addr),
    .mst_req_o_wdata   (mst_wdata),
    .mst_resp_i_gnt    (mst_gnt),
    .mst_resp_i_rvalid (mst_rvalid),
    .mst_resp_i_rdata  (mst_rdata),
    .pending_o         (pending),
    .busy_o            (busy),
    .err_o             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic up(input logic r, input logic w, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] d);
    slv_req = r; slv_we = w; slv_be = b; slv_addr = a; slv_wdata = d;
  endtask

  task automatic dn(input logic g, input logic v, input logic [31:0] d);
    mst_gnt = g; mst_rvalid = v; mst_rdata = d;
  endtask

  task automatic push_req(input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = w; r.be = b; r.addr = a; r.wdata = d;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input logic [31:0] d);
    rsp_t r;
    r.rdata = d; r.at = cyc + 1;
    exp_rsp.push_back(r);
  endtask

  task automatic rsp_burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      nxt(); dn(1'b0, 1'b1, base + 32'(i)); push_rsp(base + 32'(i));
    end
    nxt(); dn(1'b0, 1'b0, 32'h0); #1;
    chk("burst_pending0", 32'(pending), 0);
  endtask

  // Monitors: downstream request acceptance and upstream response delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_req && mst_gnt) begin
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 32'(exp_req.size()), 1);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("req_we", 32'(mst_we), 32'(r.we));
          chk("req_be", 32'(mst_be), 32'(r.be));
          chk("req_addr", mst_addr, r.addr);
          chk("req_wdata", mst_wdata, r.wdata);
        end
      end
      if (slv_rvalid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(exp_rsp.size()), 1);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_rdata", slv_rdata, r.rdata);
          chk("rsp_cycle", 32'(cyc), 32'(r.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wa[0] = 32'h2000; wa[1] = 32'h2004; wa[2] = 32'h2008; wa[3] = 32'h200C;
    wd[0] = 32'hA000_0000; wd[1] = 32'hA000_0001; wd[2] = 32'hA000_0002; wd[3] = 32'hA000_0003;
    wb[0] = 4'hF; wb[1] = 4'h3; wb[2] = 4'hC; wb[3] = 4'h1;

    rst_n = 1'b0;
    up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    dn(1'b0, 1'b0, 32'h0);
    #3;
    chk("rst_mst_req", 32'(mst_req), 0);
    chk("rst_mst_addr", mst_addr, 0);
    chk("rst_slv_rvalid", 32'(slv_rvalid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    #9 rst_n = 1'b1;

    // Single read, 3-cycle round trip
    nxt(); up(1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0); dn(1'b1, 1'b0, 32'h0); #1;
    chk("t1_gnt", 32'(slv_gnt), 1);
    chk("t1_pending0", 32'(pending), 0);
    push_req(1'b0, 4'hF, 32'h0000_1000, 32'h0);
    nxt(); up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t1_mst_req", 32'(mst_req), 1);
    chk("t1_pending1", 32'(pending), 1);
    nxt(); dn(1'b0, 1'b1, 32'hDEAD_BEEF); push_rsp(32'hDEAD_BEEF); #1;
    chk("t1_pending1b", 32'(pending), 1);
    chk("t1_no_early_rvalid", 32'(slv_rvalid), 0);
    nxt(); dn(1'b0, 1'b0, 32'h0); #1;
    chk("t1_rvalid_n3", 32'(slv_rvalid), 1);
    chk("t1_rdata", slv_rdata, 32'hDEAD_BEEF);
    chk("t1_pending_back0", 32'(pending), 0);

    // Backpressure: 4 writes, downstream gnt held low
    nxt(); dn(1'b0, 1'b0, 32'h0); up(1'b1, 1'b1, wb[0], wa[0], wd[0]); #1;
    chk("t2_gnt0", 32'(slv_gnt), 1);
    push_req(1'b1, wb[0], wa[0], wd[0]);
    nxt(); up(1'b1, 1'b1, wb[1], wa[1], wd[1]); #1;
    chk("t2_gnt1", 32'(slv_gnt), 1);
    chk("t2_head_addr", mst_addr, wa[0]);
    push_req(1'b1, wb[1], wa[1], wd[1]);
    nxt(); up(1'b1, 1'b1, wb[2], wa[2], wd[2]); #1;
    chk("t2_gnt_full", 32'(slv_gnt), 0);
    chk("t2_hold_addr", mst_addr, wa[0]);
    chk("t2_hold_wdata", mst_wdata, wd[0]);
    chk("t2_hold_be", 32'(mst_be), 32'(wb[0]));
    nxt(); #1;
    chk("t2_gnt_full2", 32'(slv_gnt), 0);
    chk("t2_hold_addr2", mst_addr, wa[0]);
    chk("t2_pending2", 32'(pending), 2);
    nxt(); dn(1'b1, 1'b0, 32'h0); #1;
    chk("t2_full_pop_nogrant", 32'(slv_gnt), 0);
    nxt(); #1;
    chk("t2_gnt_w2", 32'(slv_gnt), 1);
    push_req(1'b1, wb[2], wa[2], wd[2]);
    nxt(); up(1'b1, 1'b1, wb[3], wa[3], wd[3]); #1;
    chk("t2_gnt_w3", 32'(slv_gnt), 1);
    push_req(1'b1, wb[3], wa[3], wd[3]);
    nxt(); up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t2_pending4", 32'(pending), 4);
    nxt(); dn(1'b0, 1'b0, 32'h0); #1;
    chk("t2_drained", 32'(mst_req), 0);
    rsp_burst(4, 32'h0000_0100);

    // Outstanding limit
    for (int i = 0; i < 4; i++) begin
      nxt(); dn(1'b1, 1'b0, 32'h0); up(1'b1, 1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0); #1;
      chk("t3_gnt", 32'(slv_gnt), 1);
      push_req(1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0);
    end
    nxt(); up(1'b1, 1'b0, 4'hF, 32'h3010, 32'h0); #1;
    chk("t3_limit_gnt", 32'(slv_gnt), 0);
    chk("t3_pending4", 32'(pending), 4);
    chk("t3_busy", 32'(busy), 1);
    nxt(); dn(1'b1, 1'b1, 32'h11); push_rsp(32'h11); #1;
    chk("t3_limit_gnt2", 32'(slv_gnt), 0);
    nxt(); dn(1'b1, 1'b0, 32'h0); #1;
    chk("t3_one_more", 32'(slv_gnt), 1);
    chk("t3_pending3", 32'(pending), 3);
    push_req(1'b0, 4'hF, 32'h3010, 32'h0);
    nxt(); up(1'b1, 1'b0, 4'hF, 32'h3014, 32'h0); #1;
    chk("t3_limit_again", 32'(slv_gnt), 0);
    chk("t3_pending4b", 32'(pending), 4);
    nxt(); up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rsp_burst(4, 32'h0000_0012);

    // Simultaneous increment and decrement at pending = 2
    nxt(); dn(1'b1, 1'b0, 32'h0); up(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0); #1;
    chk("t4_gnt0", 32'(slv_gnt), 1);
    push_req(1'b0, 4'hF, 32'h4000, 32'h0);
    nxt(); up(1'b1, 1'b0, 4'hF, 32'h4004, 32'h0); #1;
    chk("t4_gnt1", 32'(slv_gnt), 1);
    push_req(1'b0, 4'hF, 32'h4004, 32'h0);
    nxt(); up(1'b1, 1'b0, 4'hF, 32'h4008, 32'h0); dn(1'b1, 1'b1, 32'h22); push_rsp(32'h22); #1;
    chk("t4_gnt2", 32'(slv_gnt), 1);
    chk("t4_pending2", 32'(pending), 2);
    push_req(1'b0, 4'hF, 32'h4008, 32'h0);
    nxt(); up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); dn(1'b1, 1'b0, 32'h0); #1;
    chk("t4_pending_hold", 32'(pending), 2);
    rsp_burst(2, 32'h0000_0023);

    // Spurious response
    nxt(); dn(1'b0, 1'b0, 32'h0); #1;
    chk("t5_pending0", 32'(pending), 0);
    chk("t5_err0", 32'(err), 0);
    nxt(); dn(1'b0, 1'b1, 32'h5A5A_5A5A); push_rsp(32'h5A5A_5A5A); #1;
    chk("t5_err_not_yet", 32'(err), 0);
    nxt(); dn(1'b0, 1'b0, 32'h0); #1;
    chk("t5_err1", 32'(err), 1);
    chk("t5_pending_stay0", 32'(pending), 0);
    chk("t5_busy0", 32'(busy), 0);
    nxt(); nxt(); #1;
    chk("t5_err_sticky", 32'(err), 1);
    chk("t5_single_pulse", 32'(slv_rvalid), 0);

    // Reset mid-burst with two queued requests
    nxt(); dn(1'b0, 1'b0, 32'h0); up(1'b1, 1'b1, 4'hF, 32'h6000, 32'h1); #1;
    chk("t6_gnt0", 32'(slv_gnt), 1);
    nxt(); up(1'b1, 1'b1, 4'hF, 32'h6004, 32'h2); #1;
    chk("t6_gnt1", 32'(slv_gnt), 1);
    nxt(); up(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t6_queued", 32'(mst_req), 1);
    chk("t6_pending2", 32'(pending), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(mst_req), 0);
    chk("t6_async_rvalid", 32'(slv_rvalid), 0);
    chk("t6_async_pending", 32'(pending), 0);
    chk("t6_err_cleared", 32'(err), 0);
    #3 rst_n = 1'b1;
    nxt(); dn(1'b1, 1'b0, 32'h0); #1;
    chk("t6_fifo_empty", 32'(mst_req), 0);
    chk("t6_pending0", 32'(pending), 0);
    chk("t6_busy0", 32'(busy), 0);
    nxt(); #1;
    chk("t6_fifo_empty2", 32'(mst_req), 0);
    nxt(); nxt(); #1;

    chk("end_req_queue", 32'(exp_req.size()), 0);
    chk("end_rsp_queue", 32'(exp_rsp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
